// File: rtl/vsc_pkg.sv
// ============================================================================
//  Module   : vsc_pkg
//  Purpose  : Shared types, default constants and MISR step for the sweep stage
//  Revision : 1.0
// ============================================================================
`default_nettype none

package vsc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned C_MAX_W    = 64;
    localparam logic [15:0] C_DEF_POLY = 16'h1021;
    localparam logic [15:0] C_DEF_SEED = 16'hFFFF;

    // Width-agnostic step: operands live in a wide container, masked to `width`.
    function automatic logic [C_MAX_W-1:0] misr_step(
        input logic [C_MAX_W-1:0] sig,
        input logic [C_MAX_W-1:0] data,
        input logic [C_MAX_W-1:0] poly,
        input int unsigned        width
    );
        logic [C_MAX_W-1:0] mask;
        logic [C_MAX_W-1:0] msb;
        logic [C_MAX_W-1:0] nxt;
        mask = (C_MAX_W'(1) << width) - C_MAX_W'(1);
        msb  = C_MAX_W'(1) << (width - 1);
        nxt  = (sig << 1) & mask;
        if ((sig & msb) != '0) begin
            nxt = nxt ^ poly;
        end
        return (nxt ^ data) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vsc_misr.sv
// ============================================================================
//  Module   : vsc_misr
//  Purpose  : Signature register; seeds on load, compacts one word per enable
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vsc_misr
    import vsc_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(C_DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = '1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             enable,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (enable) begin
            sig_d = SIG_W'(misr_step(C_MAX_W'(sig_q), C_MAX_W'(data), C_MAX_W'(POLY), SIG_W));
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

`default_nettype wire

// File: rtl/vector_sweep_capture.sv
// ============================================================================
//  Module   : vector_sweep_capture
//  Purpose  : Exhaustive input sweep with settle delay, record stream and MISR
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vector_sweep_capture
    import vsc_pkg::*;
#(
    parameter int unsigned      N_IN   = 6,
    parameter int unsigned      N_OUT  = 1,
    parameter int unsigned      SETTLE = 1,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(C_DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = '1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_vec,
    output logic [N_OUT-1:0] rec_resp,
    output logic [SIG_W-1:0] signature,
    output logic             sig_valid
);

    localparam int unsigned      CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  rec_vec_q, rec_vec_d;
    logic [N_OUT-1:0] rec_resp_q, rec_resp_d;
    logic             sig_valid_q, sig_valid_d;
    logic             w_misr_load;
    logic             w_misr_en;

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            rec_vec_q   <= '0;
            rec_resp_q  <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            rec_vec_q   <= rec_vec_d;
            rec_resp_q  <= rec_resp_d;
            sig_valid_q <= sig_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        rec_vec_d   = rec_vec_q;
        rec_resp_d  = rec_resp_q;
        sig_valid_d = sig_valid_q;
        w_misr_load = 1'b0;
        w_misr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = DRIVE;
                    vec_d       = '0;
                    cnt_d       = C_CNT_LOAD;
                    sig_valid_d = 1'b0;
                    w_misr_load = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    rec_vec_d  = vec_q;
                    rec_resp_d = resp;
                    state_d    = EMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EMIT: begin
                if (rec_ready) begin
                    w_misr_en = 1'b1;
                    // Terminate on all-ones before incrementing so the counter never wraps.
                    if (vec_q == '1) begin
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = C_CNT_LOAD;
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                sig_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        rec_valid = (state_q == EMIT);
        vec       = vec_q;
        rec_vec   = rec_vec_q;
        rec_resp  = rec_resp_q;
        sig_valid = sig_valid_q;
    end

    vsc_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CK     (CK),
        .reset  (reset),
        .load   (w_misr_load),
        .seed   (SEED),
        .enable (w_misr_en),
        .data   (SIG_W'({rec_vec_q, rec_resp_q})),
        .sig    (signature)
    );

endmodule

`default_nettype wire

// File: tb/tb_vector_sweep_capture.sv
// ============================================================================
//  Module   : tb_vector_sweep_capture
//  Purpose  : Scoreboard bench for vector_sweep_capture (SETTLE=1 and SETTLE=3)
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vector_sweep_capture;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic        reset, start_a, start_b, ready_a, ready_b, resp_mode;
    logic [5:0]  vec_a, vec_b, rec_vec_a, rec_vec_b;
    logic [0:0]  resp_a, resp_b, rec_resp_a, rec_resp_b;
    logic        busy_a, busy_b, done_a, done_b, rec_valid_a, rec_valid_b;
    logic        sig_valid_a, sig_valid_b;
    logic [15:0] signature_a, signature_b;

    // Target device modelled as the parity of its inputs, settled within the cycle.
    assign resp_a = resp_mode ? ^vec_a : 1'b0;
    assign resp_b = 1'b0;

    vector_sweep_capture u_dut_a (
        .CK(CK), .reset(reset), .start(start_a), .vec(vec_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .rec_valid(rec_valid_a), .rec_ready(ready_a),
        .rec_vec(rec_vec_a), .rec_resp(rec_resp_a), .signature(signature_a),
        .sig_valid(sig_valid_a)
    );

    vector_sweep_capture #(.SETTLE(3)) u_dut_b (
        .CK(CK), .reset(reset), .start(start_b), .vec(vec_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .rec_valid(rec_valid_b), .rec_ready(ready_b),
        .rec_vec(rec_vec_b), .rec_resp(rec_resp_b), .signature(signature_b),
        .sig_valid(sig_valid_b)
    );

    typedef struct {
        logic [5:0] v;
        logic       r;
        int         cyc;
    } rec_t;

    rec_t        q_a[$];
    rec_t        q_b[$];
    int          ec = 0;
    int          t0_a = 0, t0_b = 0;
    int          exp_done_a = -1, exp_done_b = -1;
    logic [15:0] exp_sig_a = '0, exp_sig_b = '0;
    logic [15:0] sig1;
    int          tests = 0, fails = 0;

    always @(posedge CK) ec <= ec + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mstep(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    task automatic plan(input bit to_b, input bit par, input int settle, input int n_rec,
                        input int stall_k, input int stall_n);
        logic [15:0] s;
        rec_t        e;
        s = 16'hFFFF;
        for (int k = 0; k < n_rec; k++) begin
            e.v   = 6'(k);
            e.r   = par ? ^e.v : 1'b0;
            e.cyc = (settle + 1) * (k + 1) + ((k >= stall_k) ? stall_n : 0);
            s     = mstep(s, {9'b0, e.v, e.r});
            if (to_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
        if (to_b) exp_sig_b = s;
        else      exp_sig_a = s;
    endtask

    task automatic wait_rel(input bit on_b, input int n);
        while (ec - (on_b ? t0_b : t0_a) < n) begin
            @(posedge CK); #1;
        end
    endtask

    task automatic go(input bit on_b);
        @(posedge CK); #1;
        if (on_b) begin start_b = 1'b1; t0_b = ec; end
        else      begin start_a = 1'b1; t0_a = ec; end
        @(posedge CK); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    always @(negedge CK) begin
        if (rec_valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_rec: actual vec %0d required none", rec_vec_a);
            end else begin
                rec_t e;
                e = q_a.pop_front();
                chk("a_rec_vec", rec_vec_a, e.v);
                chk("a_vec_held", vec_a, e.v);
                chk("a_rec_resp", rec_resp_a, e.r);
                chk("a_rec_cycle", ec - t0_a, e.cyc);
            end
        end
        if (rec_valid_a && !ready_a && q_a.size() > 0) begin
            chk("a_stall_rec_vec", rec_vec_a, q_a[0].v);
            chk("a_stall_vec", vec_a, q_a[0].v);
            chk("a_stall_rec_resp", rec_resp_a, q_a[0].r);
        end
        if (done_a) begin
            chk("a_done_cycle", ec - t0_a, exp_done_a);
            chk("a_signature", signature_a, exp_sig_a);
        end
    end

    always @(negedge CK) begin
        if (rec_valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_rec: actual vec %0d required none", rec_vec_b);
            end else begin
                rec_t e;
                e = q_b.pop_front();
                chk("b_rec_vec", rec_vec_b, e.v);
                chk("b_rec_resp", rec_resp_b, e.r);
                chk("b_rec_cycle", ec - t0_b, e.cyc);
            end
        end
        if (done_b) begin
            chk("b_done_cycle", ec - t0_b, exp_done_b);
            chk("b_signature", signature_b, exp_sig_b);
        end
    end

    task automatic chk_reset_a(input string tag);
        chk({tag, "_vec"}, vec_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_rec_valid"}, rec_valid_a, 0);
        chk({tag, "_rec_vec"}, rec_vec_a, 0);
        chk({tag, "_rec_resp"}, rec_resp_a, 0);
        chk({tag, "_signature"}, signature_a, 16'hFFFF);
        chk({tag, "_sig_valid"}, sig_valid_a, 0);
    endtask

    task automatic chk_end_a(input string tag);
        chk({tag, "_busy_low"}, busy_a, 0);
        chk({tag, "_sig_valid"}, sig_valid_a, 1);
        chk({tag, "_final_sig"}, signature_a, exp_sig_a);
        chk({tag, "_queue_empty"}, q_a.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; resp_mode = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        chk_reset_a("por");
        chk("por_b_busy", busy_b, 0);
        reset = 1'b0;

        // 1: plain sweep, resp tied low
        plan(1'b0, 1'b0, 1, 64, 64, 0);
        exp_done_a = 129;
        go(1'b0);
        chk("s1_busy_c1", busy_a, 1);
        chk("s1_vec_c1", vec_a, 0);
        wait_rel(1'b0, 130);
        chk_end_a("s1");
        sig1 = signature_a;
        exp_done_a = -1;

        // 2: parity response
        resp_mode = 1'b1;
        plan(1'b0, 1'b1, 1, 64, 64, 0);
        exp_done_a = 129;
        go(1'b0);
        wait_rel(1'b0, 130);
        chk_end_a("s2");
        exp_done_a = -1;
        resp_mode = 1'b0;

        // 3: five-cycle stall on vector 10
        plan(1'b0, 1'b0, 1, 64, 10, 5);
        exp_done_a = 134;
        go(1'b0);
        for (int c = 22; c < 27; c++) begin
            wait_rel(1'b0, c);
            ready_a = 1'b0;
            chk("s3_valid_held", rec_valid_a, 1);
        end
        wait_rel(1'b0, 27);
        ready_a = 1'b1;
        wait_rel(1'b0, 135);
        chk_end_a("s3");
        chk("s3_sig_vs_s1", signature_a, sig1);
        exp_done_a = -1;

        // 4: SETTLE=3 instance
        plan(1'b1, 1'b0, 3, 64, 64, 0);
        exp_done_b = 257;
        go(1'b1);
        wait_rel(1'b1, 3);
        chk("s4_no_valid_c3", rec_valid_b, 0);
        wait_rel(1'b1, 4);
        chk("s4_valid_c4", rec_valid_b, 1);
        wait_rel(1'b1, 258);
        chk("s4_busy_low", busy_b, 0);
        chk("s4_sig_valid", sig_valid_b, 1);
        chk("s4_sig_vs_s1", signature_b, sig1);
        chk("s4_queue_empty", q_b.size(), 0);
        exp_done_b = -1;

        // 5: reset mid-sweep, then a fresh sweep
        plan(1'b0, 1'b0, 1, 25, 64, 0);
        go(1'b0);
        wait_rel(1'b0, 50);
        reset = 1'b1;
        wait_rel(1'b0, 51);
        reset = 1'b0;
        chk_reset_a("s5_rst");
        chk("s5_partial_consumed", q_a.size(), 0);
        plan(1'b0, 1'b0, 1, 64, 64, 0);
        exp_done_a = 129;
        go(1'b0);
        wait_rel(1'b0, 130);
        chk_end_a("s5");
        exp_done_a = -1;

        // 6: extra start pulses while busy are dropped
        plan(1'b0, 1'b0, 1, 64, 64, 0);
        exp_done_a = 129;
        go(1'b0);
        wait_rel(1'b0, 40);
        start_a = 1'b1;
        wait_rel(1'b0, 41);
        start_a = 1'b0;
        wait_rel(1'b0, 129);
        start_a = 1'b1;
        wait_rel(1'b0, 130);
        start_a = 1'b0;
        chk("s6_busy_c130", busy_a, 0);
        wait_rel(1'b0, 140);
        chk("s6_busy_c140", busy_a, 0);
        chk("s6_queue_empty", q_a.size(), 0);
        exp_done_a = -1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
